evr_link_decoder: RTL and testbench
===================================

// Module: evr_link_decoder
// PURPOSE
//  Receive-side counterpart of the event generator transmit path. Decodes the 16-bit
//  8b10b-decoded event link stream: byte 0 carries event codes/commas, byte 1 the
//  distributed bus. Recovers the heartbeat, ping and diagnostic bits, measures the
//  heartbeat interval and ping half-period, and tracks link sync and code errors.
//  Sits between the receive transceiver wrapper and receiver-side timing logic.
// PARAMETERS
//  RXCLK_NOMINAL_FREQUENCY  125000000  nominal evrRxClk rate; sets HB_WIDTH=$clog2(F)+2
//  DISTRIBUTED_BUS_WIDTH    8          width of evrDistributedBus (<=8; taken from byte 1 LSBs)
//  SYNC_COMMAS              4          consecutive error-free commas needed to declare link up
//  LINK_TIMEOUT_CYCLES      1024       cycles without a comma before link declared down
//  PING_WIDTH               16         width of ping half-period measurement
// PORTS
//  evrRxClk              in   1       receive clock; the only clock
//  evrRxReset            in   1       synchronous, active-high reset
//  evrRxData             in   16      [7:0] event code/comma, [15:8] distributed bus
//  evrRxCharIsK          in   2       per-byte K-character flags
//  evrStatsClear         in   1       one-cycle pulse: zero evrCodeErrorCount
//  evrLinkUp             out  1       link FSM in UP
//  evrEventStrobe        out  1       one-cycle pulse: evrEventCode valid
//  evrEventCode          out  8       last received non-zero event code
//  evrDistributedBus     out  DBW     latched distributed bus
//  evrHeartbeatMarker    out  1       one-cycle pulse on dBus[0] rising edge
//  evrHeartbeatInterval  out  HB_WIDTH cycles between last two heartbeat markers
//  evrHeartbeatValid     out  1       evrHeartbeatInterval holds a real measurement
//  evrPingToggle         out  1       one-cycle pulse on any dBus[1] edge
//  evrPingHalfPeriod     out  PING_WIDTH cycles between last two ping edges
//  evrDiag               out  1       dBus[2]
//  evrCodeErrorCount     out  16      saturating count of illegal K characters
// BEHAVIOUR
//  - Reset: every output 0, FSM=DOWN, all internal counters 0.
//  - Input stage: evrRxData/evrRxCharIsK registered once (d_r, k_r); all decode from d_r/k_r.
//  - comma = k_r[0] & d_r[7:0]==8'hBC. codeErr = (k_r[0] & ~comma) | k_r[1].
//  - Link FSM: DOWN -comma-> SYNC (commaCnt=1). SYNC: comma -> commaCnt+1; commaCnt reaches
//    SYNC_COMMAS -> UP; codeErr -> DOWN (wins over simultaneous comma). UP: watchdog counts
//    cycles since last comma, cleared by comma; watchdog==LINK_TIMEOUT_CYCLES-1 -> DOWN.
//    codeErr in UP counted only, no state change. Reset mid-operation -> DOWN next cycle.
//  - Event: in UP, ~k_r[0] & d_r[7:0]!=0 -> evrEventStrobe=1, evrEventCode=d_r[7:0] the
//    cycle after d_r; 2-cycle latency from input port. Code 0 = idle, no strobe.
//  - dBus: in UP, ~k_r[1] -> evrDistributedBus<=d_r[DBW-1+8:8] (2-cycle latency). Entering
//    DOWN clears evrDistributedBus, evrHeartbeatValid, edge history; outputs held at 0 in DOWN.
//  - Heartbeat: hbCnt increments each cycle, saturates at all-ones. dBus[0] 0->1 (UP only):
//    marker pulse 1 cycle after dBus update; evrHeartbeatInterval<=hbCnt; hbCnt<=1.
//    evrHeartbeatValid set on 2nd marker since entering UP (first interval discarded).
//  - Ping: same scheme on either dBus[1] edge; pingCnt saturates at all-ones; no valid flag.
//  - Error count: +1 per codeErr cycle in any state, saturates at 16'hFFFF. evrStatsClear
//    same cycle as codeErr -> count loads 1; clear alone -> 0.
//  - No bus edge detection across DOWN->UP: first dBus sample after UP sets history only.
// TESTING
//  - Reset, then 4 frames {8'h00,8'hBC} K=2'b01 spaced 8 cycles -> evrLinkUp=1 after 4th comma.
//  - In SYNC inject K=2'b10 byte1 -> FSM DOWN, evrCodeErrorCount=1; clear pulse -> 0.
//  - UP, send event 8'h7A K=0 -> evrEventStrobe 1 cycle, evrEventCode=8'h7A, 2 cycles after
//    input; event 8'h00 -> no strobe.
//  - UP, dBus[0] rising every 1000 cycles -> 2nd marker sets Valid, Interval=1000; ping bit
//    toggling every 625 cycles -> evrPingHalfPeriod=625.
//  - UP, stop commas 1024 cycles -> evrLinkUp=0, evrDistributedBus=0, evrHeartbeatValid=0.
//  - Force 70000 error cycles -> evrCodeErrorCount saturates at 16'hFFFF, no wrap.

Source files
------------

// File: rtl/evr_link_decoder.sv
// Receive-side event link decoder: link sync FSM, event strobes, distributed bus
// latch, heartbeat/ping interval measurement and code error statistics.
module evr_link_decoder #(
  parameter int RXCLK_NOMINAL_FREQUENCY = 125000000,
  parameter int DISTRIBUTED_BUS_WIDTH   = 8,
  parameter int SYNC_COMMAS             = 4,
  parameter int LINK_TIMEOUT_CYCLES     = 1024,
  parameter int PING_WIDTH              = 16,
  localparam int HB_WIDTH               = $clog2(RXCLK_NOMINAL_FREQUENCY) + 2,
  localparam int DBW                    = DISTRIBUTED_BUS_WIDTH
) (
  input  logic                  evrRxClk,
  input  logic                  evrRxReset,
  input  logic [15:0]           evrRxData,
  input  logic [1:0]            evrRxCharIsK,
  input  logic                  evrStatsClear,
  output logic                  evrLinkUp,
  output logic                  evrEventStrobe,
  output logic [7:0]            evrEventCode,
  output logic [DBW-1:0]        evrDistributedBus,
  output logic                  evrHeartbeatMarker,
  output logic [HB_WIDTH-1:0]   evrHeartbeatInterval,
  output logic                  evrHeartbeatValid,
  output logic                  evrPingToggle,
  output logic [PING_WIDTH-1:0] evrPingHalfPeriod,
  output logic                  evrDiag,
  output logic [15:0]           evrCodeErrorCount
);

  localparam logic [1:0] ST_DOWN = 2'd0;
  localparam logic [1:0] ST_SYNC = 2'd1;
  localparam logic [1:0] ST_UP   = 2'd2;
  localparam int CC_W = $clog2(SYNC_COMMAS + 1);
  localparam int WD_W = $clog2(LINK_TIMEOUT_CYCLES) + 1;

  logic [15:0]           r_d;
  logic [1:0]            r_k;
  logic [1:0]            r_state;
  logic [CC_W-1:0]       r_comma_cnt;
  logic [WD_W-1:0]       r_wd;
  logic                  r_strobe;
  logic [7:0]            r_code;
  logic [DBW-1:0]        r_dbus;
  logic                  r_hist_vld;
  logic                  r_rise_q;
  logic                  r_ping_q;
  logic                  r_marker;
  logic                  r_toggle;
  logic                  r_hb_seen;
  logic                  r_hb_valid;
  logic [HB_WIDTH-1:0]   r_hb_cnt;
  logic [HB_WIDTH-1:0]   r_hb_int;
  logic [PING_WIDTH-1:0] r_ping_cnt;
  logic [PING_WIDTH-1:0] r_ping_half;
  logic [15:0]           r_err_cnt;

  logic                  w_comma;
  logic                  w_code_err;
  logic                  w_is_up;
  logic                  w_event;
  logic                  w_go_down;
  logic [1:0]            w_old_lo;
  logic [1:0]            w_new_lo;
  logic                  w_diag;
  logic [1:0]            w_state_next;
  logic [CC_W-1:0]       w_comma_cnt_next;
  logic [WD_W-1:0]       w_wd_next;

  assign w_comma    = r_k[0] & (r_d[7:0] == 8'hBC);
  assign w_code_err = (r_k[0] & ~w_comma) | r_k[1];
  assign w_is_up    = (r_state == ST_UP);
  assign w_event    = w_is_up & ~r_k[0] & (r_d[7:0] != 8'h00);

  // Narrow buses simply lack the ping/diag bits; treat missing bits as constant 0.
  generate
    if (DBW >= 2) begin : g_lo2
      assign w_old_lo = r_dbus[1:0];
      assign w_new_lo = r_d[9:8];
    end else begin : g_lo1
      assign w_old_lo = {1'b0, r_dbus[0]};
      assign w_new_lo = {1'b0, r_d[8]};
    end
    if (DBW >= 3) begin : g_diag
      assign w_diag = r_dbus[2];
    end else begin : g_nodiag
      assign w_diag = 1'b0;
    end
  endgenerate

  always_comb begin
    w_state_next     = r_state;
    w_comma_cnt_next = r_comma_cnt;
    w_wd_next        = r_wd;
    w_go_down        = 1'b0;
    case (r_state)
      ST_DOWN: begin
        if (w_comma) begin
          w_comma_cnt_next = CC_W'(1);
          w_wd_next        = '0;
          w_state_next     = (SYNC_COMMAS <= 1) ? ST_UP : ST_SYNC;
        end
      end
      ST_SYNC: begin
        w_wd_next = '0;
        if (w_code_err) begin
          w_state_next = ST_DOWN;
          w_go_down    = 1'b1;
        end else if (w_comma) begin
          w_comma_cnt_next = r_comma_cnt + 1'b1;
          if (w_comma_cnt_next == CC_W'(SYNC_COMMAS)) w_state_next = ST_UP;
        end
      end
      ST_UP: begin
        // Code errors while up are only counted; only comma starvation drops the link.
        if (w_comma) begin
          w_wd_next = '0;
        end else if (r_wd == WD_W'(LINK_TIMEOUT_CYCLES - 1)) begin
          w_state_next = ST_DOWN;
          w_go_down    = 1'b1;
        end else begin
          w_wd_next = r_wd + 1'b1;
        end
      end
      default: w_state_next = ST_DOWN;
    endcase
  end

  always_ff @(posedge evrRxClk) begin
    if (evrRxReset) begin
      r_d         <= '0;
      r_k         <= '0;
      r_state     <= ST_DOWN;
      r_comma_cnt <= '0;
      r_wd        <= '0;
      r_strobe    <= 1'b0;
      r_code      <= '0;
      r_dbus      <= '0;
      r_hist_vld  <= 1'b0;
      r_rise_q    <= 1'b0;
      r_ping_q    <= 1'b0;
      r_marker    <= 1'b0;
      r_toggle    <= 1'b0;
      r_hb_seen   <= 1'b0;
      r_hb_valid  <= 1'b0;
      r_hb_cnt    <= '0;
      r_hb_int    <= '0;
      r_ping_cnt  <= '0;
      r_ping_half <= '0;
      r_err_cnt   <= '0;
    end else begin
      r_d         <= evrRxData;
      r_k         <= evrRxCharIsK;
      r_state     <= w_state_next;
      r_comma_cnt <= w_comma_cnt_next;
      r_wd        <= w_wd_next;
      r_strobe    <= w_event;
      if (w_event) r_code <= r_d[7:0];

      if (evrStatsClear) r_err_cnt <= {15'd0, w_code_err};
      else if (w_code_err && (r_err_cnt != 16'hFFFF)) r_err_cnt <= r_err_cnt + 1'b1;

      // Edges detected on the previous bus update are reported one cycle later.
      r_marker <= r_rise_q;
      r_toggle <= r_ping_q;
      if (r_rise_q) begin
        r_hb_int  <= r_hb_cnt;
        r_hb_cnt  <= HB_WIDTH'(1);
        r_hb_seen <= 1'b1;
        if (r_hb_seen) r_hb_valid <= 1'b1;
      end else if (r_hb_cnt != '1) begin
        r_hb_cnt <= r_hb_cnt + 1'b1;
      end
      if (r_ping_q) begin
        r_ping_half <= r_ping_cnt;
        r_ping_cnt  <= PING_WIDTH'(1);
      end else if (r_ping_cnt != '1) begin
        r_ping_cnt <= r_ping_cnt + 1'b1;
      end

      r_rise_q <= 1'b0;
      r_ping_q <= 1'b0;
      if (w_go_down) begin
        r_dbus     <= '0;
        r_hist_vld <= 1'b0;
        r_hb_seen  <= 1'b0;
        r_hb_valid <= 1'b0;
      end else if (w_is_up && !r_k[1]) begin
        r_dbus     <= r_d[8 +: DBW];
        r_hist_vld <= 1'b1;
        r_rise_q   <= r_hist_vld & ~w_old_lo[0] & w_new_lo[0];
        r_ping_q   <= r_hist_vld & (w_old_lo[1] ^ w_new_lo[1]);
      end
    end
  end

  assign evrLinkUp            = w_is_up;
  assign evrEventStrobe       = r_strobe;
  assign evrEventCode         = r_code;
  assign evrDistributedBus    = r_dbus;
  assign evrHeartbeatMarker   = r_marker;
  assign evrHeartbeatInterval = r_hb_int;
  assign evrHeartbeatValid    = r_hb_valid;
  assign evrPingToggle        = r_toggle;
  assign evrPingHalfPeriod    = r_ping_half;
  assign evrDiag              = w_diag;
  assign evrCodeErrorCount    = r_err_cnt;

endmodule

// File: tb/tb_evr_link_decoder.sv
// Bench for evr_link_decoder: cycle-level reference model compared every cycle,
// plus directed literal checks at the interesting points of each scenario.
module tb_evr_link_decoder;

  localparam int F   = 125000000;
  localparam int DBW = 8;
  localparam int SC  = 4;
  localparam int TO  = 1024;
  localparam int PW  = 16;
  localparam int HBW = $clog2(F) + 2;
  localparam longint HBMAX  = (longint'(1) << HBW) - 1;
  localparam longint PMAX   = (longint'(1) << PW) - 1;
  localparam longint DBMASK = (longint'(1) << DBW) - 1;

  logic           clk = 1'b0;
  logic           evrRxReset;
  logic [15:0]    evrRxData;
  logic [1:0]     evrRxCharIsK;
  logic           evrStatsClear;
  logic           evrLinkUp;
  logic           evrEventStrobe;
  logic [7:0]     evrEventCode;
  logic [DBW-1:0] evrDistributedBus;
  logic           evrHeartbeatMarker;
  logic [HBW-1:0] evrHeartbeatInterval;
  logic           evrHeartbeatValid;
  logic           evrPingToggle;
  logic [PW-1:0]  evrPingHalfPeriod;
  logic           evrDiag;
  logic [15:0]    evrCodeErrorCount;

  always #4 clk = ~clk;

  evr_link_decoder #(
    .RXCLK_NOMINAL_FREQUENCY(F),
    .DISTRIBUTED_BUS_WIDTH(DBW),
    .SYNC_COMMAS(SC),
    .LINK_TIMEOUT_CYCLES(TO),
    .PING_WIDTH(PW)
  ) dut (
    .evrRxClk(clk),
    .evrRxReset(evrRxReset),
    .evrRxData(evrRxData),
    .evrRxCharIsK(evrRxCharIsK),
    .evrStatsClear(evrStatsClear),
    .evrLinkUp(evrLinkUp),
    .evrEventStrobe(evrEventStrobe),
    .evrEventCode(evrEventCode),
    .evrDistributedBus(evrDistributedBus),
    .evrHeartbeatMarker(evrHeartbeatMarker),
    .evrHeartbeatInterval(evrHeartbeatInterval),
    .evrHeartbeatValid(evrHeartbeatValid),
    .evrPingToggle(evrPingToggle),
    .evrPingHalfPeriod(evrPingHalfPeriod),
    .evrDiag(evrDiag),
    .evrCodeErrorCount(evrCodeErrorCount)
  );

  int checks = 0;
  int failures = 0;
  bit cmp_en = 1'b0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h time=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: link state by name, time measured as absolute cycle numbers.
  int          m_st;        // 0 down, 1 sync, 2 up
  int          m_commas;
  int          m_markers;
  longint      m_cyc = 0;
  longint      m_last_comma;
  longint      m_hb_base;
  longint      m_pg_base;
  logic [15:0] m_pd;
  logic [1:0]  m_pk;
  bit          m_hist;
  bit          m_pend_hb;
  bit          m_pend_pg;
  longint e_up, e_strobe, e_code, e_dbus, e_marker, e_int, e_valid, e_toggle, e_half, e_err;

  always @(posedge clk) begin : model
    bit     comma, err, was_up, go_down;
    longint nb, span;
    m_cyc++;
    if (evrRxReset) begin
      m_st = 0; m_commas = 0; m_markers = 0; m_last_comma = 0;
      m_hist = 0; m_pend_hb = 0; m_pend_pg = 0;
      m_hb_base = m_cyc; m_pg_base = m_cyc;
      m_pd = '0; m_pk = '0;
      e_up = 0; e_strobe = 0; e_code = 0; e_dbus = 0; e_marker = 0;
      e_int = 0; e_valid = 0; e_toggle = 0; e_half = 0; e_err = 0;
      cmp_en = 1'b1;
    end else begin
      comma = m_pk[0] && (m_pd[7:0] == 8'hBC);
      err   = (m_pk[0] && !comma) || m_pk[1];
      if (evrStatsClear) e_err = err ? 1 : 0;
      else if (err && e_err < 65535) e_err++;

      e_marker = m_pend_hb ? 1 : 0;
      e_toggle = m_pend_pg ? 1 : 0;
      if (m_pend_hb) begin
        span = m_cyc - 1 - m_hb_base;
        e_int = (span > HBMAX) ? HBMAX : span;
        m_hb_base = m_cyc - 1;
        m_markers++;
        if (m_markers >= 2) e_valid = 1;
      end
      if (m_pend_pg) begin
        span = m_cyc - 1 - m_pg_base;
        e_half = (span > PMAX) ? PMAX : span;
        m_pg_base = m_cyc - 1;
      end

      was_up = (m_st == 2);
      go_down = 0;
      e_strobe = 0;
      if (was_up && !m_pk[0] && m_pd[7:0] != 8'h00) begin
        e_strobe = 1;
        e_code = longint'(m_pd[7:0]);
      end
      case (m_st)
        0: if (comma) begin
          m_commas = 1;
          if (SC <= 1) begin m_st = 2; m_last_comma = m_cyc; end
          else m_st = 1;
        end
        1: if (err) begin
          m_st = 0; go_down = 1;
        end else if (comma) begin
          m_commas++;
          if (m_commas >= SC) begin m_st = 2; m_last_comma = m_cyc; end
        end
        default: if (comma) m_last_comma = m_cyc;
        else if (m_cyc - m_last_comma >= TO) begin m_st = 0; go_down = 1; end
      endcase
      e_up = (m_st == 2) ? 1 : 0;

      m_pend_hb = 0;
      m_pend_pg = 0;
      if (go_down) begin
        e_dbus = 0; m_hist = 0; e_valid = 0; m_markers = 0;
      end else if (was_up && !m_pk[1]) begin
        nb = longint'(m_pd[15:8]) & DBMASK;
        if (m_hist) begin
          m_pend_hb = (e_dbus[0] == 1'b0) && (nb[0] == 1'b1);
          m_pend_pg = (e_dbus[1] != nb[1]);
        end
        m_hist = 1;
        e_dbus = nb;
      end
      m_pd = evrRxData;
      m_pk = evrRxCharIsK;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("link_up",      longint'(evrLinkUp),            e_up);
      chk("strobe",       longint'(evrEventStrobe),       e_strobe);
      chk("code",         longint'(evrEventCode),         e_code);
      chk("dbus",         longint'(evrDistributedBus),    e_dbus);
      chk("hb_marker",    longint'(evrHeartbeatMarker),   e_marker);
      chk("hb_interval",  longint'(evrHeartbeatInterval), e_int);
      chk("hb_valid",     longint'(evrHeartbeatValid),    e_valid);
      chk("ping_toggle",  longint'(evrPingToggle),        e_toggle);
      chk("ping_half",    longint'(evrPingHalfPeriod),    e_half);
      chk("diag",         longint'(evrDiag),              (e_dbus >> 2) & 1);
      chk("err_count",    longint'(evrCodeErrorCount),    e_err);
    end
  end

  logic [7:0] cur_bus = 8'h00;

  task automatic frame(input logic [7:0] b0, input logic [1:0] k, input bit clr);
    evrRxData     = {cur_bus, b0};
    evrRxCharIsK  = k;
    evrStatsClear = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) frame(8'h00, 2'b00, 1'b0);
  endtask

  task automatic comma();
    frame(8'hBC, 2'b01, 1'b0);
  endtask

  initial begin
    evrRxReset = 1'b1; evrRxData = '0; evrRxCharIsK = '0; evrStatsClear = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_link_up",   longint'(evrLinkUp), 0);
    chk("rst_err_count", longint'(evrCodeErrorCount), 0);
    chk("rst_dbus",      longint'(evrDistributedBus), 0);
    evrRxReset = 1'b0;
    idle(4);

    // Two commas into SYNC, then a byte-1 K error drops back to DOWN.
    comma(); idle(7); comma(); idle(7);
    frame(8'h00, 2'b10, 1'b0); idle(1);
    chk("sync_err_link", longint'(evrLinkUp), 0);
    chk("sync_err_count", longint'(evrCodeErrorCount), 1);
    frame(8'h00, 2'b00, 1'b1);
    chk("clear_count", longint'(evrCodeErrorCount), 0);
    idle(3);

    for (int i = 0; i < 4; i++) begin
      comma();
      if (i < 3) idle(7);
    end
    chk("up_pending", longint'(evrLinkUp), 0);
    idle(1);
    chk("up_after_4", longint'(evrLinkUp), 1);
    idle(3);

    frame(8'h7A, 2'b00, 1'b0);
    chk("ev_lat1", longint'(evrEventStrobe), 0);
    idle(1);
    chk("ev_strobe", longint'(evrEventStrobe), 1);
    chk("ev_code", longint'(evrEventCode), 8'h7A);
    idle(1);
    chk("ev_one_cycle", longint'(evrEventStrobe), 0);
    frame(8'h00, 2'b00, 1'b0); idle(1);
    chk("ev_zero_idle", longint'(evrEventStrobe), 0);
    chk("ev_code_held", longint'(evrEventCode), 8'h7A);

    // Heartbeat rises at t=200,1200,2200; ping toggles every 625; diag every 300.
    for (int t = 0; t < 2400; t++) begin
      cur_bus[0]   = (((t + 800) % 1000) < 500);
      cur_bus[1]   = (((t / 625) % 2) == 1);
      cur_bus[2]   = (((t / 300) % 2) == 1);
      cur_bus[7:3] = 5'(t / 64);
      if (t % 100 == 50) comma();
      else if (t % 97 == 13) frame(8'(t) | 8'h01, 2'b00, 1'b0);
      else frame(8'h00, 2'b00, 1'b0);
      if (t == 500) chk("hb_valid_first", longint'(evrHeartbeatValid), 0);
    end
    chk("hb_valid", longint'(evrHeartbeatValid), 1);
    chk("hb_interval_1000", longint'(evrHeartbeatInterval), 1000);
    chk("ping_half_625", longint'(evrPingHalfPeriod), 625);

    // Comma starvation: link survives 1024 cycles, drops on the 1025th.
    comma();
    idle(1024);
    chk("wd_still_up", longint'(evrLinkUp), 1);
    idle(1);
    chk("wd_down", longint'(evrLinkUp), 0);
    chk("wd_dbus", longint'(evrDistributedBus), 0);
    chk("wd_hb_valid", longint'(evrHeartbeatValid), 0);

    repeat (65600) frame(8'h00, 2'b10, 1'b0);
    idle(1);
    chk("err_saturate", longint'(evrCodeErrorCount), 16'hFFFF);
    frame(8'h00, 2'b10, 1'b0);
    frame(8'h00, 2'b00, 1'b1);
    chk("clear_with_err", longint'(evrCodeErrorCount), 1);
    frame(8'h00, 2'b00, 1'b1);
    chk("clear_alone", longint'(evrCodeErrorCount), 0);

    // Reset while up returns the link to DOWN on the next edge.
    cur_bus = 8'h00;
    for (int i = 0; i < 4; i++) begin
      comma(); idle(3);
    end
    chk("reup", longint'(evrLinkUp), 1);
    evrRxReset = 1'b1;
    frame(8'h00, 2'b00, 1'b0);
    chk("midrst_link", longint'(evrLinkUp), 0);
    evrRxReset = 1'b0;
    idle(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
